regfile_mp_sb: RTL and testbench
================================

// Module: regfile_mp_sb
// PURPOSE
//  Parametrised multi-read-port register file with write bypass, optional hardwired-zero
//  register 0, and a per-register busy scoreboard for pipeline RAW/WAW hazard tracking.
//  Sits between decode (reads, reservations) and writeback (writes) of the CPU pipeline.
//  Reads are registered: one-cycle latency.
// PARAMETERS
//  DATA_W    32  register width in bits
//  ADDR_W    5   address width; DEPTH = 2**ADDR_W registers
//  NUM_RD    2   number of independent read ports (1..4)
//  ZERO_REG  1   1: register 0 always reads 0, is never written, is never busy
//  BYPASS    1   1: a same-cycle write to a read address returns wr_data on that read
// PORTS
//  clk       in   1               clock; all state updates on posedge
//  rst_n     in   1               asynchronous active-low reset
//  rd_addr   in   NUM_RD*ADDR_W   read addresses; port i = bits [i*ADDR_W +: ADDR_W]
//  rd_data   out  NUM_RD*DATA_W   registered read data; port i = [i*DATA_W +: DATA_W]
//  rd_ready  out  NUM_RD          registered: 1 = register read on port i was not busy
//  wr_en     in   1               write strobe from writeback
//  wr_addr   in   ADDR_W          write address
//  wr_data   in   DATA_W          write data
//  rsv_en    in   1               reservation request: mark rsv_addr busy (new producer)
//  rsv_addr  in   ADDR_W          register to reserve
//  rsv_ok    out  1               combinational: reservation accepted this cycle
//  busy_cnt  out  ADDR_W+1        registered count of busy registers
// BEHAVIOUR
//  Reset (rst_n=0, async): all registers, busy bits, rd_data, rd_ready, busy_cnt -> 0.
//   Reset asserted mid-operation discards any in-flight write or reservation.
//  Write: on posedge with wr_en=1, reg[wr_addr] <= wr_data, busy[wr_addr] <= 0.
//   ZERO_REG=1 and wr_addr=0: write ignored. Writing a non-busy register is legal.
//  Read: on posedge, rd_data[i] <= value of reg[rd_addr[i]] with this cycle's write applied
//   when BYPASS=1 (wr_en && wr_addr==rd_addr[i]); when BYPASS=0, old value is returned.
//   ZERO_REG=1 and rd_addr[i]=0: rd_data[i] <= 0, rd_ready[i] <= 1.
//  rd_ready[i] <= ~busy_next[rd_addr[i]] when BYPASS=1 (write clearing busy counts);
//   <= ~busy[rd_addr[i]] (current value) when BYPASS=0.
//  Reservation: rsv_ok = rsv_en && (~busy[rsv_addr] || (wr_en && wr_addr==rsv_addr)).
//   Reserving an already-busy register is refused (WAW): rsv_ok=0, no state change;
//   requester stalls and retries. Accepted: busy[rsv_addr] <= 1 at posedge.
//   ZERO_REG=1 and rsv_addr=0: rsv_ok=1, busy bit never set.
//  Simultaneous write + accepted reservation, same address: write data lands, busy ends 1
//   (reservation wins). Different addresses: both take effect independently.
//  busy_cnt <= popcount of busy_next; max DEPTH (ZERO_REG=1: DEPTH-1), never wraps.
//  All read ports are fully independent; any ports may share an address.
//  No X propagation: unwritten registers read 0 after reset.
// TESTING
//  1. Reset, then read all 32 addrs on both ports -> rd_data=0, rd_ready=1, busy_cnt=0.
//  2. Write 0xDEADBEEF to r5; next cycle read r5 -> rd_data=0xDEADBEEF one cycle later;
//     same-cycle write+read r5 -> 0xDEADBEEF (BYPASS=1) / old value (BYPASS=0).
//  3. Write 0x1234 to r0, read r0 -> 0 (ZERO_REG=1); 0x1234 (ZERO_REG=0).
//  4. Reserve r7 -> rsv_ok=1, busy_cnt=1, read r7 rd_ready=0; reserve r7 again -> rsv_ok=0;
//     write r7=0x55 -> busy_cnt=0, rd_ready=1, rd_data=0x55.
//  5. r9 busy; same cycle write r9=0xAA and reserve r9 -> rsv_ok=1, reg=0xAA, r9 stays busy.
//  6. Reserve r3,r4,r6, assert rst_n=0 between clock edges -> outputs 0 immediately,
//     busy_cnt=0; after release, all reads rd_ready=1, data 0.

Source files
------------

// File: rtl/regfile_mp_sb.sv
// Multi-read-port register file with write bypass, optional hardwired-zero r0 and a
// per-register busy scoreboard for RAW/WAW hazard tracking between decode and writeback.
module regfile_mp_sb #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned NUM_RD   = 2,
  parameter int unsigned ZERO_REG = 1,
  parameter int unsigned BYPASS   = 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_RD*ADDR_W-1:0]   rd_addr,
  output logic [NUM_RD*DATA_W-1:0]   rd_data,
  output logic [NUM_RD-1:0]          rd_ready,
  input  logic                       wr_en,
  input  logic [ADDR_W-1:0]          wr_addr,
  input  logic [DATA_W-1:0]          wr_data,
  input  logic                       rsv_en,
  input  logic [ADDR_W-1:0]          rsv_addr,
  output logic                       rsv_ok,
  output logic [ADDR_W:0]            busy_cnt
);

  localparam int unsigned       DEPTH     = 1 << ADDR_W;
  localparam bit                ZERO_EN   = (ZERO_REG != 0);
  localparam bit                BYP_EN    = (BYPASS != 0);
  localparam logic [ADDR_W-1:0] ADDR_ZERO = {ADDR_W{1'b0}};

  logic [DATA_W-1:0]        regs_q [DEPTH];
  logic [DEPTH-1:0]         busy_q, busy_d;
  logic [NUM_RD*DATA_W-1:0] rd_data_q, rd_data_d;
  logic [NUM_RD-1:0]        rd_ready_q, rd_ready_d;
  logic [ADDR_W:0]          busy_cnt_q, busy_cnt_d;
  logic                     wr_eff_s;
  logic                     rsv_ok_s;
  logic                     rsv_set_s;

  function automatic logic [ADDR_W:0] popcount(input logic [DEPTH-1:0] v);
    logic [ADDR_W:0] c;
    c = {(ADDR_W+1){1'b0}};
    for (int k = 0; k < DEPTH; k++) begin
      c = c + {{ADDR_W{1'b0}}, v[k]};
    end
    return c;
  endfunction

  // Effective write, reservation acceptance and next-state busy vector
  always_comb begin
    wr_eff_s = wr_en && !(ZERO_EN && (wr_addr == ADDR_ZERO));
    if (ZERO_EN && (rsv_addr == ADDR_ZERO)) begin
      rsv_ok_s  = rsv_en;
      rsv_set_s = 1'b0;
    end else begin
      // A write retiring the current producer frees the slot for the new one
      rsv_ok_s  = rsv_en && (!busy_q[rsv_addr] || (wr_en && (wr_addr == rsv_addr)));
      rsv_set_s = rsv_ok_s;
    end
    busy_d              = busy_q;
    busy_d[wr_addr]     = busy_d[wr_addr] & ~wr_eff_s;
    busy_d[rsv_addr]    = busy_d[rsv_addr] | rsv_set_s;
    busy_cnt_d          = popcount(busy_d);
  end

  // Per-port read data and readiness, with optional same-cycle write forwarding
  always_comb begin
    logic [ADDR_W-1:0] a;
    rd_data_d  = {(NUM_RD*DATA_W){1'b0}};
    rd_ready_d = {NUM_RD{1'b0}};
    a          = ADDR_ZERO;
    for (int i = 0; i < NUM_RD; i++) begin
      a = rd_addr[i*ADDR_W +: ADDR_W];
      if (ZERO_EN && (a == ADDR_ZERO)) begin
        rd_data_d[i*DATA_W +: DATA_W] = {DATA_W{1'b0}};
        rd_ready_d[i]                 = 1'b1;
      end else begin
        if (BYP_EN && wr_eff_s && (wr_addr == a)) begin
          rd_data_d[i*DATA_W +: DATA_W] = wr_data;
        end else begin
          rd_data_d[i*DATA_W +: DATA_W] = regs_q[a];
        end
        if (BYP_EN) begin
          rd_ready_d[i] = ~busy_d[a];
        end else begin
          rd_ready_d[i] = ~busy_q[a];
        end
      end
    end
  end

  // Register array storage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < DEPTH; k++) begin
        regs_q[k] <= {DATA_W{1'b0}};
      end
    end else if (wr_eff_s) begin
      regs_q[wr_addr] <= wr_data;
    end
  end

  // Scoreboard state and registered read outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q     <= {DEPTH{1'b0}};
      rd_data_q  <= {(NUM_RD*DATA_W){1'b0}};
      rd_ready_q <= {NUM_RD{1'b0}};
      busy_cnt_q <= {(ADDR_W+1){1'b0}};
    end else begin
      busy_q     <= busy_d;
      rd_data_q  <= rd_data_d;
      rd_ready_q <= rd_ready_d;
      busy_cnt_q <= busy_cnt_d;
    end
  end

  assign rd_data  = rd_data_q;
  assign rd_ready = rd_ready_q;
  assign busy_cnt = busy_cnt_q;
  assign rsv_ok   = rsv_ok_s;

endmodule

// File: tb/tb_regfile_mp_sb.sv
// Table-driven bench for regfile_mp_sb (default parameters) with an expected-result queue
// and a hand-written asynchronous-reset sequence.
module tb_regfile_mp_sb;

  typedef struct {
    logic [4:0]  a0, a1;
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic        re;
    logic [4:0]  ra;
    logic        ok;
    logic [31:0] d0;
    logic        r0;
    logic [31:0] d1;
    logic        r1;
    logic [5:0]  cnt;
  } vec_t;

  logic        clk;
  logic        rst_n;
  logic [9:0]  rd_addr;
  logic [63:0] rd_data;
  logic [1:0]  rd_ready;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic        rsv_en;
  logic [4:0]  rsv_addr;
  logic        rsv_ok;
  logic [5:0]  busy_cnt;

  int   pass_cnt;
  int   total_cnt;
  vec_t exp_q[$];
  vec_t tbl[15];

  regfile_mp_sb dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .rd_ready (rd_ready),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .rsv_en   (rsv_en),
    .rsv_addr (rsv_addr),
    .rsv_ok   (rsv_ok),
    .busy_cnt (busy_cnt)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(input logic [4:0] a0, input logic [4:0] a1, input logic we,
                              input logic [4:0] wa, input logic [31:0] wd, input logic re,
                              input logic [4:0] ra, input logic ok, input logic [31:0] d0,
                              input logic r0, input logic [31:0] d1, input logic r1,
                              input logic [5:0] cnt);
    vec_t v;
    v.a0 = a0; v.a1 = a1; v.we = we; v.wa = wa; v.wd = wd; v.re = re; v.ra = ra;
    v.ok = ok; v.d0 = d0; v.r0 = r0; v.d1 = d1; v.r1 = r1; v.cnt = cnt;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) begin
      pass_cnt++;
    end else begin
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Drive on the falling edge, check rsv_ok combinationally, then compare registered outputs.
  task automatic apply(input vec_t v);
    vec_t e;
    @(negedge clk);
    rd_addr  = {v.a1, v.a0};
    wr_en    = v.we;
    wr_addr  = v.wa;
    wr_data  = v.wd;
    rsv_en   = v.re;
    rsv_addr = v.ra;
    #1;
    chk("rsv_ok", {63'd0, rsv_ok}, {63'd0, v.ok});
    exp_q.push_back(v);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    chk("rd_data0", {32'd0, rd_data[31:0]},  {32'd0, e.d0});
    chk("rd_ready0", {63'd0, rd_ready[0]},   {63'd0, e.r0});
    chk("rd_data1", {32'd0, rd_data[63:32]}, {32'd0, e.d1});
    chk("rd_ready1", {63'd0, rd_ready[1]},   {63'd0, e.r1});
    chk("busy_cnt", {58'd0, busy_cnt},       {58'd0, e.cnt});
  endtask

  initial begin
    clk = 1'b0; rst_n = 1'b0; pass_cnt = 0; total_cnt = 0;
    rd_addr = 10'd0; wr_en = 1'b0; wr_addr = 5'd0; wr_data = 32'd0;
    rsv_en = 1'b0; rsv_addr = 5'd0;

    //     a0 a1  we wa  wd            re ra  ok d0            r0 d1            r1 cnt
    tbl[0]  = mk(5, 5,  1, 5,  32'hDEADBEEF, 0, 0,  0, 32'hDEADBEEF, 1, 32'hDEADBEEF, 1, 0);
    tbl[1]  = mk(5, 0,  0, 0,  32'h0,        0, 0,  0, 32'hDEADBEEF, 1, 32'h0,        1, 0);
    tbl[2]  = mk(0, 0,  1, 0,  32'h1234,     0, 0,  0, 32'h0,        1, 32'h0,        1, 0);
    tbl[3]  = mk(0, 5,  0, 0,  32'h0,        0, 0,  0, 32'h0,        1, 32'hDEADBEEF, 1, 0);
    tbl[4]  = mk(7, 7,  0, 0,  32'h0,        1, 7,  1, 32'h0,        0, 32'h0,        0, 1);
    tbl[5]  = mk(7, 5,  0, 0,  32'h0,        1, 7,  0, 32'h0,        0, 32'hDEADBEEF, 1, 1);
    tbl[6]  = mk(7, 7,  1, 7,  32'h55,       0, 0,  0, 32'h55,       1, 32'h55,       1, 0);
    tbl[7]  = mk(7, 7,  0, 0,  32'h0,        0, 0,  0, 32'h55,       1, 32'h55,       1, 0);
    tbl[8]  = mk(9, 7,  0, 0,  32'h0,        1, 9,  1, 32'h0,        0, 32'h55,       1, 1);
    tbl[9]  = mk(9, 9,  1, 9,  32'hAA,       1, 9,  1, 32'hAA,       0, 32'hAA,       0, 1);
    tbl[10] = mk(9, 0,  0, 0,  32'h0,        0, 0,  0, 32'hAA,       0, 32'h0,        1, 1);
    tbl[11] = mk(0, 9,  0, 0,  32'h0,        1, 0,  1, 32'h0,        1, 32'hAA,       0, 1);
    tbl[12] = mk(9, 10, 1, 9,  32'hBB,       1, 10, 1, 32'hBB,       1, 32'h0,        0, 1);
    tbl[13] = mk(11,10, 1, 11, 32'h77,       1, 10, 0, 32'h77,       1, 32'h0,        0, 1);
    tbl[14] = mk(10,11, 1, 10, 32'h10,       0, 0,  0, 32'h10,       1, 32'h77,       1, 0);

    repeat (2) @(negedge clk);
    chk("reset_rd_data", rd_data, 64'd0);
    chk("reset_rd_ready", {62'd0, rd_ready}, 64'd0);
    chk("reset_busy_cnt", {58'd0, busy_cnt}, 64'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 32; i++) begin
      apply(mk(i[4:0], 5'd31 - i[4:0], 0, 0, 32'h0, 0, 0, 0, 32'h0, 1, 32'h0, 1, 0));
    end

    for (int i = 0; i < 15; i++) begin
      apply(tbl[i]);
    end

    // Reserve r3, r4, r6 then reset asynchronously in mid-cycle with a write and reservation pending
    apply(mk(3, 4, 0, 0, 32'h0, 1, 3, 1, 32'h0, 0, 32'h0,        1, 1));
    apply(mk(4, 3, 0, 0, 32'h0, 1, 4, 1, 32'h0, 0, 32'h0,        0, 2));
    apply(mk(6, 5, 0, 0, 32'h0, 1, 6, 1, 32'h0, 0, 32'hDEADBEEF, 1, 3));
    @(negedge clk);
    rd_addr = {5'd5, 5'd5}; wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'h0BAD;
    rsv_en = 1'b1; rsv_addr = 5'd8;
    #2 rst_n = 1'b0;
    #1;
    chk("async_rd_data", rd_data, 64'd0);
    chk("async_rd_ready", {62'd0, rd_ready}, 64'd0);
    chk("async_busy_cnt", {58'd0, busy_cnt}, 64'd0);
    @(negedge clk);
    wr_en = 1'b0; rsv_en = 1'b0;
    rst_n = 1'b1;
    apply(mk(3, 4, 0, 0, 32'h0, 0, 0, 0, 32'h0, 1, 32'h0, 1, 0));
    apply(mk(5, 6, 0, 0, 32'h0, 0, 0, 0, 32'h0, 1, 32'h0, 1, 0));
    apply(mk(8, 7, 0, 0, 32'h0, 0, 0, 0, 32'h0, 1, 32'h0, 1, 0));
    apply(mk(3, 0, 0, 0, 32'h0, 1, 3, 1, 32'h0, 0, 32'h0, 1, 1));

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
